// File: rtl/c432_irq_dispatch.sv
// c432_irq_dispatch: deglitches the c432 priority-encoder outputs and offers
// one interrupt at a time to the CPU, tracks service until EOI, then waits a
// hold-off gap before dispatching again.
// Optional service watchdog: define IRQ_TIMEOUT_EN.
//
// Handshake: irq_valid rises with irq_bus/irq_chan stable and stays high,
// unchanged, until the rising clock edge where irq_ready is also high; that
// edge is the transfer. irq_ready while irq_valid is low has no effect.
module c432_irq_dispatch #(
    parameter int STABLE_CYCLES  = 2,
    parameter int HOLDOFF_CYCLES = 4,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pa,
    input  logic             pb,
    input  logic             pc,
    input  logic [3:0]       chan_in,
    output logic             irq_valid,
    output logic [1:0]       irq_bus,
    output logic [3:0]       irq_chan,
    input  logic             irq_ready,
    input  logic             eoi,
    output logic             busy,
    output logic [CNT_W-1:0] irq_count,
    output logic             timeout_err,
    output logic [2:0]       state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FILTER  = 3'd1,
        S_PRESENT = 3'd2,
        S_SERVICE = 3'd3,
        S_HOLDOFF = 3'd4
    } state_t;

    localparam logic [3:0]       STABLE_L  = 4'(STABLE_CYCLES);
    localparam logic [3:0]       HOLD_LAST = 4'(HOLDOFF_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    state_t           state_q, state_d;
    logic [1:0]       in_bus_q, in_bus_d;
    logic [3:0]       in_chan_q, in_chan_d;
    logic [5:0]       cap_src_q, cap_src_d;
    logic [3:0]       stab_cnt_q, stab_cnt_d;
    logic [3:0]       hold_cnt_q, hold_cnt_d;
    logic             irq_valid_q, irq_valid_d;
    logic [1:0]       irq_bus_q, irq_bus_d;
    logic [3:0]       irq_chan_q, irq_chan_d;
    logic             busy_q, busy_d;
    logic [CNT_W-1:0] irq_count_q, irq_count_d;
    logic [5:0]       src_now;
    logic             release_svc;

`ifdef IRQ_TIMEOUT_EN
    localparam logic [7:0] WD_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] wd_cnt_q, wd_cnt_d;
    logic       timeout_err_q, timeout_err_d;
`endif

    assign src_now = {in_bus_q, in_chan_q};

    // Encode bus priority pa > pb > pc ahead of the input register.
    always_comb begin
        in_chan_d = chan_in;
        if (pa)      in_bus_d = 2'd1;
        else if (pb) in_bus_d = 2'd2;
        else if (pc) in_bus_d = 2'd3;
        else         in_bus_d = 2'd0;
    end

    // Dispatch FSM: filter, offer, service, hold-off; all outputs registered.
    always_comb begin
        state_d     = state_q;
        cap_src_d   = cap_src_q;
        stab_cnt_d  = stab_cnt_q;
        hold_cnt_d  = hold_cnt_q;
        irq_valid_d = irq_valid_q;
        irq_bus_d   = irq_bus_q;
        irq_chan_d  = irq_chan_q;
        busy_d      = busy_q;
        irq_count_d = irq_count_q;
        release_svc = 1'b0;
`ifdef IRQ_TIMEOUT_EN
        wd_cnt_d      = wd_cnt_q;
        timeout_err_d = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (in_bus_q != 2'd0) begin
                    cap_src_d  = src_now;
                    stab_cnt_d = 4'd1;
                    if (STABLE_L == 4'd1) begin
                        // A single stable sample is already enough.
                        state_d     = S_PRESENT;
                        irq_valid_d = 1'b1;
                        irq_bus_d   = src_now[5:4];
                        irq_chan_d  = src_now[3:0];
                    end else begin
                        state_d = S_FILTER;
                    end
                end
            end
            S_FILTER: begin
                if (in_bus_q == 2'd0) begin
                    state_d    = S_IDLE;
                    stab_cnt_d = 4'd0;
                end else if (src_now != cap_src_q) begin
                    cap_src_d  = src_now;
                    stab_cnt_d = 4'd1;
                end else begin
                    stab_cnt_d = stab_cnt_q + 4'd1;
                    if (stab_cnt_q + 4'd1 == STABLE_L) begin
                        state_d     = S_PRESENT;
                        irq_valid_d = 1'b1;
                        irq_bus_d   = cap_src_q[5:4];
                        irq_chan_d  = cap_src_q[3:0];
                    end
                end
            end
            S_PRESENT: begin
                if (irq_ready) begin
                    state_d     = S_SERVICE;
                    irq_valid_d = 1'b0;
                    irq_bus_d   = 2'd0;
                    busy_d      = 1'b1;
                    stab_cnt_d  = 4'd0;
                    if (irq_count_q != CNT_MAX) irq_count_d = irq_count_q + 1'b1;
`ifdef IRQ_TIMEOUT_EN
                    wd_cnt_d = 8'd0;
`endif
                end
            end
            S_SERVICE: begin
                if (eoi) begin
                    release_svc = 1'b1;
`ifdef IRQ_TIMEOUT_EN
                end else if (wd_cnt_q == WD_LAST) begin
                    // Watchdog expiry; an eoi on the same edge takes the branch above.
                    release_svc   = 1'b1;
                    timeout_err_d = 1'b1;
                end else begin
                    wd_cnt_d = wd_cnt_q + 8'd1;
`endif
                end
            end
            S_HOLDOFF: begin
                if (hold_cnt_q == HOLD_LAST) begin
                    state_d    = S_IDLE;
                    hold_cnt_d = 4'd0;
                end else begin
                    hold_cnt_d = hold_cnt_q + 4'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (release_svc) begin
            busy_d     = 1'b0;
            hold_cnt_d = 4'd0;
            state_d    = (HOLDOFF_CYCLES == 0) ? S_IDLE : S_HOLDOFF;
        end
    end

    // State and output registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            in_bus_q    <= 2'd0;
            in_chan_q   <= 4'd0;
            cap_src_q   <= 6'd0;
            stab_cnt_q  <= 4'd0;
            hold_cnt_q  <= 4'd0;
            irq_valid_q <= 1'b0;
            irq_bus_q   <= 2'd0;
            irq_chan_q  <= 4'd0;
            busy_q      <= 1'b0;
            irq_count_q <= '0;
        end else begin
            state_q     <= state_d;
            in_bus_q    <= in_bus_d;
            in_chan_q   <= in_chan_d;
            cap_src_q   <= cap_src_d;
            stab_cnt_q  <= stab_cnt_d;
            hold_cnt_q  <= hold_cnt_d;
            irq_valid_q <= irq_valid_d;
            irq_bus_q   <= irq_bus_d;
            irq_chan_q  <= irq_chan_d;
            busy_q      <= busy_d;
            irq_count_q <= irq_count_d;
        end
    end

`ifdef IRQ_TIMEOUT_EN
    // Watchdog counter and its one-cycle error pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt_q      <= 8'd0;
            timeout_err_q <= 1'b0;
        end else begin
            wd_cnt_q      <= wd_cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end
    assign timeout_err = timeout_err_q;
`else
    assign timeout_err = 1'b0;
`endif

    assign irq_valid = irq_valid_q;
    assign irq_bus   = irq_bus_q;
    assign irq_chan  = irq_chan_q;
    assign busy      = busy_q;
    assign irq_count = irq_count_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_c432_irq_dispatch.sv
// Bench for c432_irq_dispatch: per-cycle vector table followed by directed
// sequences for reset, counter saturation and the service watchdog.
module tb_c432_irq_dispatch;

    logic       clk;
    logic       rst_n;
    logic       pa, pb, pc;
    logic [3:0] chan_in;
    logic       irq_valid;
    logic [1:0] irq_bus;
    logic [3:0] irq_chan;
    logic       irq_ready;
    logic       eoi;
    logic       busy;
    logic [7:0] irq_count;
    logic       timeout_err;
    logic [2:0] state_dbg;

    int checks;
    int failures;
    logic [7:0] exp_q[$];

    c432_irq_dispatch #(
        .STABLE_CYCLES (2),
        .HOLDOFF_CYCLES(4),
        .TIMEOUT_CYCLES(10),
        .CNT_W         (8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pa         (pa),
        .pb         (pb),
        .pc         (pc),
        .chan_in    (chan_in),
        .irq_valid  (irq_valid),
        .irq_bus    (irq_bus),
        .irq_chan   (irq_chan),
        .irq_ready  (irq_ready),
        .eoi        (eoi),
        .busy       (busy),
        .irq_count  (irq_count),
        .timeout_err(timeout_err),
        .state_dbg  (state_dbg)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] abc;     // {pa,pb,pc}
        logic [3:0] chan;
        logic [1:0] re;      // {irq_ready,eoi}
        logic       e_valid;
        logic [1:0] e_bus;
        logic [3:0] e_chan;
        logic       e_busy;
        logic [7:0] e_cnt;
    } vec_t;

    vec_t tbl[28];

    function automatic vec_t mk(input logic [2:0] abc, input logic [3:0] ch,
                                input logic [1:0] re, input logic ev,
                                input logic [1:0] eb, input logic [3:0] ec,
                                input logic eby, input logic [7:0] ecnt);
        vec_t v;
        v.abc = abc; v.chan = ch; v.re = re; v.e_valid = ev;
        v.e_bus = eb; v.e_chan = ec; v.e_busy = eby; v.e_cnt = ecnt;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input int budget, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < budget; n++) begin
            tick();
            if (irq_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic drive(input vec_t v);
        {pa, pb, pc} = v.abc;
        chan_in      = v.chan;
        {irq_ready, eoi} = v.re;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_valid"}, 32'(irq_valid), 32'd0);
        chk({tag, "_bus"},   32'(irq_bus),   32'd0);
        chk({tag, "_chan"},  32'(irq_chan),  32'd0);
        chk({tag, "_busy"},  32'(busy),      32'd0);
        chk({tag, "_count"}, 32'(irq_count), 32'd0);
        chk({tag, "_terr"},  32'(timeout_err), 32'd0);
        chk({tag, "_state"}, 32'(state_dbg), 32'd0);
    endtask

    initial begin
        bit ok;
        int exp_model;
        logic [7:0] exp_cnt;

        checks   = 0;
        failures = 0;
        rst_n = 1'b0;
        pa = 1'b1; pb = 1'b0; pc = 1'b0; chan_in = 4'h5;
        irq_ready = 1'b0; eoi = 1'b0;

        // Rows: edge k after reset release; inputs driven before edge k.
        tbl[0]  = mk(3'b100, 4'h5, 2'b00, 1'b0, 2'd0, 4'h0, 1'b0, 8'd0);
        tbl[1]  = mk(3'b100, 4'h5, 2'b00, 1'b0, 2'd0, 4'h0, 1'b0, 8'd0);
        tbl[2]  = mk(3'b100, 4'h5, 2'b00, 1'b1, 2'd1, 4'h5, 1'b0, 8'd0);
        tbl[3]  = mk(3'b010, 4'h9, 2'b00, 1'b1, 2'd1, 4'h5, 1'b0, 8'd0);
        tbl[4]  = mk(3'b010, 4'h9, 2'b01, 1'b1, 2'd1, 4'h5, 1'b0, 8'd0);
        tbl[5]  = mk(3'b010, 4'h9, 2'b10, 1'b0, 2'd0, 4'h5, 1'b1, 8'd1);
        tbl[6]  = mk(3'b010, 4'h9, 2'b00, 1'b0, 2'd0, 4'h5, 1'b1, 8'd1);
        tbl[7]  = mk(3'b010, 4'h9, 2'b01, 1'b0, 2'd0, 4'h5, 1'b0, 8'd1);
        tbl[8]  = mk(3'b010, 4'h9, 2'b10, 1'b0, 2'd0, 4'h5, 1'b0, 8'd1);
        tbl[9]  = mk(3'b010, 4'h9, 2'b01, 1'b0, 2'd0, 4'h5, 1'b0, 8'd1);
        tbl[10] = mk(3'b010, 4'h9, 2'b00, 1'b0, 2'd0, 4'h5, 1'b0, 8'd1);
        tbl[11] = mk(3'b010, 4'h9, 2'b00, 1'b0, 2'd0, 4'h5, 1'b0, 8'd1);
        tbl[12] = mk(3'b010, 4'h9, 2'b00, 1'b0, 2'd0, 4'h5, 1'b0, 8'd1);
        tbl[13] = mk(3'b010, 4'h9, 2'b00, 1'b1, 2'd2, 4'h9, 1'b0, 8'd1);
        tbl[14] = mk(3'b010, 4'h9, 2'b10, 1'b0, 2'd0, 4'h9, 1'b1, 8'd2);
        tbl[15] = mk(3'b000, 4'h0, 2'b01, 1'b0, 2'd0, 4'h9, 1'b0, 8'd2);
        for (int i = 16; i < 20; i++)
            tbl[i] = mk(3'b000, 4'h0, 2'b00, 1'b0, 2'd0, 4'h9, 1'b0, 8'd2);
        tbl[20] = mk(3'b010, 4'h3, 2'b01, 1'b0, 2'd0, 4'h9, 1'b0, 8'd2);
        tbl[21] = mk(3'b010, 4'h7, 2'b00, 1'b0, 2'd0, 4'h9, 1'b0, 8'd2);
        tbl[22] = mk(3'b010, 4'h3, 2'b00, 1'b0, 2'd0, 4'h9, 1'b0, 8'd2);
        tbl[23] = mk(3'b010, 4'h7, 2'b00, 1'b0, 2'd0, 4'h9, 1'b0, 8'd2);
        tbl[24] = mk(3'b010, 4'h7, 2'b00, 1'b0, 2'd0, 4'h9, 1'b0, 8'd2);
        tbl[25] = mk(3'b010, 4'h7, 2'b00, 1'b1, 2'd2, 4'h7, 1'b0, 8'd2);
        tbl[26] = mk(3'b000, 4'h0, 2'b10, 1'b0, 2'd0, 4'h7, 1'b1, 8'd3);
        tbl[27] = mk(3'b000, 4'h0, 2'b01, 1'b0, 2'd0, 4'h7, 1'b0, 8'd3);

        // Reset state
        tick();
        tick();
        check_all_zero("reset");

        // Release reset between edges, then walk the table.
        @(posedge clk);
        #2 rst_n = 1'b1;
        for (int i = 0; i < 28; i++) begin
            @(negedge clk);
            drive(tbl[i]);
            tick();
            chk($sformatf("v%0d_valid", i + 1), 32'(irq_valid), 32'(tbl[i].e_valid));
            chk($sformatf("v%0d_bus", i + 1),   32'(irq_bus),   32'(tbl[i].e_bus));
            chk($sformatf("v%0d_chan", i + 1),  32'(irq_chan),  32'(tbl[i].e_chan));
            chk($sformatf("v%0d_busy", i + 1),  32'(busy),      32'(tbl[i].e_busy));
            chk($sformatf("v%0d_count", i + 1), 32'(irq_count), 32'(tbl[i].e_cnt));
            chk($sformatf("v%0d_terr", i + 1),  32'(timeout_err), 32'd0);
        end

        // Reset while an offer is pending.
        @(negedge clk);
        pa = 1'b1; pb = 1'b0; pc = 1'b0; chan_in = 4'hA; irq_ready = 1'b0; eoi = 1'b0;
        wait_valid(20, ok);
        chk("present_seen", 32'(ok), 32'd1);
        chk("present_chan", 32'(irq_chan), 32'hA);
        #1 rst_n = 1'b0;
        #1;
        check_all_zero("rst_present");

        // Reset during service.
        @(negedge clk);
        rst_n = 1'b1;
        wait_valid(20, ok);
        chk("svc_offer_seen", 32'(ok), 32'd1);
        @(negedge clk);
        irq_ready = 1'b1;
        tick();
        chk("svc_busy", 32'(busy), 32'd1);
        chk("svc_count", 32'(irq_count), 32'd1);
        @(negedge clk);
        irq_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check_all_zero("rst_service");

        // Saturation of the serviced counter with pc held.
        @(negedge clk);
        rst_n = 1'b1;
        pa = 1'b0; pb = 1'b0; pc = 1'b1; chan_in = 4'hC;
        exp_model = 0;
        for (int k = 0; k < 300; k++) begin
            wait_valid(20, ok);
            chk("sat_offer_seen", 32'(ok), 32'd1);
            if (!ok) break;
            chk("sat_bus", 32'(irq_bus), 32'd3);
            chk("sat_chan", 32'(irq_chan), 32'hC);
            @(negedge clk);
            irq_ready = 1'b1;
            tick();
            if (exp_model < 255) exp_model++;
            exp_q.push_back(8'(exp_model));
            exp_cnt = exp_q.pop_front();
            chk("sat_count", 32'(irq_count), 32'(exp_cnt));
            @(negedge clk);
            irq_ready = 1'b0;
            eoi = 1'b1;
            tick();
            chk("sat_busy_off", 32'(busy), 32'd0);
            @(negedge clk);
            eoi = 1'b0;
        end
        chk("sat_final", 32'(irq_count), 32'd255);

        @(negedge clk);
        rst_n = 1'b0;
        pa = 1'b1; pc = 1'b0; chan_in = 4'h2;
        @(negedge clk);
        rst_n = 1'b1;

        // Service watchdog.
        wait_valid(20, ok);
        chk("wd_offer_seen", 32'(ok), 32'd1);
        @(negedge clk);
        irq_ready = 1'b1;
        tick();
        chk("wd_entry_busy", 32'(busy), 32'd1);
        @(negedge clk);
        irq_ready = 1'b0;
`ifdef IRQ_TIMEOUT_EN
        for (int c = 1; c <= 10; c++) begin
            tick();
            chk($sformatf("wd_c%0d_terr", c), 32'(timeout_err), (c == 10) ? 32'd1 : 32'd0);
            chk($sformatf("wd_c%0d_busy", c), 32'(busy), (c == 10) ? 32'd0 : 32'd1);
        end
        tick();
        chk("wd_pulse_end", 32'(timeout_err), 32'd0);
        wait_valid(20, ok);
        chk("wd2_offer_seen", 32'(ok), 32'd1);
        @(negedge clk);
        irq_ready = 1'b1;
        tick();
        chk("wd2_entry_busy", 32'(busy), 32'd1);
        irq_ready = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            eoi = (c == 10);
            tick();
            chk($sformatf("wd2_c%0d_terr", c), 32'(timeout_err), 32'd0);
            chk($sformatf("wd2_c%0d_busy", c), 32'(busy), (c == 10) ? 32'd0 : 32'd1);
        end
        @(negedge clk);
        eoi = 1'b0;
        tick();
        chk("wd2_after_terr", 32'(timeout_err), 32'd0);
`else
        for (int c = 1; c <= 20; c++) begin
            tick();
            chk($sformatf("nowd_c%0d_busy", c), 32'(busy), 32'd1);
            chk($sformatf("nowd_c%0d_terr", c), 32'(timeout_err), 32'd0);
        end
        @(negedge clk);
        eoi = 1'b1;
        tick();
        chk("nowd_eoi_busy", 32'(busy), 32'd0);
        @(negedge clk);
        eoi = 1'b0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/c432_irq_dispatch.md
Name: c432_irq_dispatch

Overview:
- Sequential stage directly downstream of the c432 27-channel interrupt priority encoder.
- Consumes c432's combinational outputs: bus indicators PA/PB/PC (N223/N329/N370) and the 4-bit channel code (N421/N430/N431/N432).
- Deglitches them and presents one interrupt at a time to the CPU through a valid/ready handshake.
- Tracks the service phase until end-of-interrupt (EOI), then enforces a hold-off gap before the next dispatch.

Parameters:
- STABLE_CYCLES, 2: consecutive identical samples required before dispatch (1..15).
- HOLDOFF_CYCLES, 4: idle cycles after EOI before filtering resumes (0..15).
- TIMEOUT_CYCLES, 255: service watchdog limit. Used only with IRQ_TIMEOUT_EN (1..255).
- CNT_W, 8: width of the serviced-interrupt counter.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- pa  in  1  bus A request present (c432 N223).
- pb  in  1  bus B request present (c432 N329).
- pc  in  1  bus C request present (c432 N370).
- chan_in  in  4  channel code {N421,N430,N431,N432}.
- irq_valid  out  1  interrupt offered to CPU.
- irq_bus  out  2  1=A, 2=B, 3=C. 0 when not valid.
- irq_chan  out  4  registered channel code.
- irq_ready  in  1  CPU accepts the offered interrupt.
- eoi  in  1  single-cycle end-of-interrupt from CPU.
- busy  out  1  high in SERVICE.
- irq_count  out  CNT_W  accepted-interrupt count, saturating.
- timeout_err  out  1  one-cycle pulse on watchdog expiry. Tied 0 without IRQ_TIMEOUT_EN.

Behaviour:
- Reset (asynchronous, rst_n=0): state=IDLE, irq_valid=0, irq_bus=0, irq_chan=0, busy=0, irq_count=0, timeout_err=0, all internal counters 0.
- Input sampling:
  - pa, pb, pc and chan_in are registered once every cycle.
  - src = {bus,chan}. Bus priority: pa>pb>pc. Bus=0 if none are set.
  - Input-to-irq_valid latency = 1 + STABLE_CYCLES cycles.
- State IDLE:
  - Registered bus!=0 -> FILTER, stable counter=1, captured src stored.
- State FILTER:
  - Registered bus==0 -> IDLE.
  - src differs from captured -> recapture, counter=1, stay in FILTER.
  - src equal -> counter+1. When counter reaches STABLE_CYCLES -> PRESENT and drive irq_valid=1, irq_bus/irq_chan=captured.
- State PRESENT:
  - irq_valid, irq_bus and irq_chan are held constant until handshake. Input changes are ignored and the offer is never withdrawn.
  - irq_valid & irq_ready on a rising edge -> SERVICE. Next cycle: irq_valid=0, irq_bus=0, busy=1, irq_count+1 (saturates at all-ones).
  - irq_chan keeps its last value through SERVICE.
- State SERVICE:
  - eoi=1 -> HOLDOFF, busy=0.
  - If HOLDOFF_CYCLES=0, go directly to IDLE.
- State HOLDOFF:
  - Counts HOLDOFF_CYCLES cycles, then -> IDLE. Inputs are ignored.
- eoi asserted in any state other than SERVICE: ignored.
- ready without valid: ignored.
- Request still present after HOLDOFF: re-filtered and re-dispatched, because c432 is level-based.
- Reset during any state: immediate return to reset values. No partial transfer is reported.

Optional Feature:
- Macro: IRQ_TIMEOUT_EN.
- With the macro:
  - A watchdog counter clears on entry to SERVICE and increments each SERVICE cycle.
  - At TIMEOUT_CYCLES without eoi: pulse timeout_err for 1 cycle, go to HOLDOFF, busy=0.
  - eoi in the same cycle as expiry: eoi wins and timeout_err stays 0.
- Without the macro: no watchdog logic. timeout_err is constant 0 and SERVICE waits indefinitely for eoi.

Test Plan:
- Reset release with pa=1, chan_in=4'h5, irq_ready=0 -> irq_valid rises on cycle 3 (default STABLE_CYCLES=2), irq_bus=1, irq_chan=5, held until ready.
- pb=1 with chan_in toggling 3,7,3,7 each cycle -> irq_valid never rises. chan_in then held at 7 -> valid after 3 cycles with irq_bus=2, irq_chan=7.
- Valid offered, ready=1 for one cycle -> next cycle irq_valid=0, busy=1, irq_count=1. eoi pulse -> busy=0, no new valid for 4 hold-off cycles plus filter latency.
- pc=1 held continuously, CPU acks and sends eoi repeatedly 300 times with CNT_W=8 -> irq_count saturates at 255. irq_bus=3 on every offer.
- rst_n pulsed low in SERVICE and in PRESENT -> all outputs 0 asynchronously, irq_count=0.
- With IRQ_TIMEOUT_EN and TIMEOUT_CYCLES=10: accept, no eoi -> timeout_err pulses 10 cycles after SERVICE entry, then busy=0. Repeat with eoi on cycle 10 -> timeout_err=0.
